// File: rtl/auth_pkg.sv
// Shared types and constants for the digest compare block.
package auth_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE,
    S_LOCK
  } state_e;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  localparam logic [255:0] REF_DIGEST_DEF =
    256'he42c30a65a37f031fe920210a999325f84dc75c7ee90d4d2543cef1936d3fb36;

endpackage

// File: rtl/auth_fail_counter.sv
// Saturating count of consecutive failed compares.
module auth_fail_counter #(
  parameter int MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic       sat,
  output logic [3:0] value
);

  assign sat = (value == 4'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !sat) begin
      value <= value + 4'd1;
    end
  end

endmodule

// File: rtl/auth_digest_check.sv
// Word-serial digest compare with saturating fail count.
// Optional lockout after MAX_FAIL failures: define AUTH_LOCKOUT_EN.
module auth_digest_check
  import auth_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS = 8,
  parameter int MAX_FAIL = 3,
  parameter logic [DATA_W*WORDS-1:0] REF_DIGEST = REF_DIGEST_DEF,
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  inout  wire               vpp,
  inout  wire               gnd,
  input  logic              cs,
  input  logic              we,
  input  logic              wc,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              digest_valid,
  output logic              busy,
  output logic              locked,
  output logic [3:0]        fail_cnt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

  logic [1:0] rst_sync;
  logic       rst_n;

  // async assert, clk-synchronous release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] cand [WORDS];
  logic [DATA_W-1:0] ref_w [WORDS];
  logic [ADDR_W-1:0] idx_q;
  logic              sticky_q;
  logic              res_pend;
  logic              res_mis;
  logic              valid_q;

  for (genvar g = 0; g < WORDS; g++) begin : g_ref
    assign ref_w[g] = REF_DIGEST[g*DATA_W +: DATA_W];
  end

  logic accept;
  logic word_wr;
  logic ctl_clr;
  logic ctl_start;
  logic addr_ok;
  logic mis_now;
  logic last;
  logic fail_inc;
  logic fail_clr;
  logic fail_sat;
  logic [3:0] fail_val;

  assign accept    = cs & we
                   & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign addr_ok   = (int'(address) < WORDS);
  assign word_wr   = accept & ~wc & addr_ok;
  assign ctl_clr   = accept & wc & write_data[CTRL_CLEAR];
  assign ctl_start = accept & wc & write_data[CTRL_START]
                   & ~write_data[CTRL_CLEAR];
  assign mis_now   = (cand[idx_q] != ref_w[idx_q]);
  assign last      = (idx_q == LAST);
  assign fail_inc  = res_pend & res_mis;
  assign fail_clr  = res_pend & ~res_mis;

  auth_fail_counter #(
    .MAX (MAX_FAIL)
  ) u_fail (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_inc),
    .clr   (fail_clr),
    .sat   (fail_sat),
    .value (fail_val)
  );

`ifdef AUTH_LOCKOUT_EN
  logic lock_hit;
  assign lock_hit = fail_inc & (int'(fail_val) + 1 >= MAX_FAIL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (ctl_start) state_d = S_CMP;
      S_CMP:          if (last) state_d = S_DONE;
      S_LOCK:         state_d = S_LOCK;
      default:        state_d = S_IDLE;
    endcase
`ifdef AUTH_LOCKOUT_EN
    if (lock_hit) state_d = S_LOCK;
`endif
  end

  // result lands one edge after the last word is compared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) cand[i] <= '0;
      idx_q    <= '0;
      sticky_q <= 1'b0;
      res_pend <= 1'b0;
      res_mis  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      res_pend <= 1'b0;
      if (state_q == S_CMP) begin
        idx_q    <= idx_q + 1'b1;
        sticky_q <= sticky_q | mis_now;
        if (last) begin
          res_pend <= 1'b1;
          res_mis  <= sticky_q | mis_now;
        end
      end
      if (ctl_start) begin
        idx_q    <= '0;
        sticky_q <= 1'b0;
      end
      if (res_pend) valid_q <= ~res_mis;
      if (word_wr) begin
        cand[address] <= write_data;
        valid_q       <= 1'b0;
      end
      if (ctl_clr) begin
        for (int i = 0; i < WORDS; i++) cand[i] <= '0;
        valid_q <= 1'b0;
      end
      if (state_d == S_LOCK) valid_q <= 1'b0;
    end
  end

  assign digest_valid = valid_q;
  assign busy         = (state_q == S_CMP);
  assign fail_cnt     = fail_val;

`ifdef AUTH_LOCKOUT_EN
  assign locked = (state_q == S_LOCK);
`else
  assign locked = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{vpp, gnd, fail_sat};

endmodule

// File: tb/tb_auth_digest_check.sv
// Scoreboard bench for auth_digest_check (default parameters).
module tb_auth_digest_check;

  localparam logic [255:0] REFD =
    256'he42c30a65a37f031fe920210a999325f84dc75c7ee90d4d2543cef1936d3fb36;
  localparam int MAXF = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic        wc = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] write_data = '0;
  logic        digest_valid;
  logic        busy;
  logic        locked;
  logic [3:0]  fail_cnt;
  wire         vpp;
  wire         gnd;

  assign vpp = 1'b1;
  assign gnd = 1'b0;

  always #5 clk = ~clk;

  auth_digest_check dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vpp          (vpp),
    .gnd          (gnd),
    .cs           (cs),
    .we           (we),
    .wc           (wc),
    .address      (address),
    .write_data   (write_data),
    .digest_valid (digest_valid),
    .busy         (busy),
    .locked       (locked),
    .fail_cnt     (fail_cnt)
  );

  typedef struct {
    bit valid;
    int cnt;
    bit lock;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mcand [8];
  logic [31:0] refw [8];
  bit          mvalid;
  int          mfail;
  bit          mlock;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mcand[i] = '0;
    mvalid = 0;
    mfail = 0;
    mlock = 0;
  endtask

  task automatic wr_word(input int a, input logic [31:0] d, input bit upd);
    cs = 1; we = 1; wc = 0;
    address = 3'(a);
    write_data = d;
    tick();
    cs = 0; we = 0;
    if (upd) begin
      mcand[a] = d;
      mvalid = 0;
    end
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    cs = 1; we = 1; wc = 1;
    write_data = d;
    tick();
    cs = 0; we = 0; wc = 0;
  endtask

  task automatic load_ref();
    for (int i = 0; i < 8; i++) wr_word(i, refw[i], 1);
  endtask

  task automatic do_compare(input string tag, input bit poke);
    bit   match;
    bit   prev;
    int   n;
    exp_t e;
    exp_t got;
    match = 1;
    for (int i = 0; i < 8; i++)
      if (mcand[i] !== refw[i]) match = 0;
    if (match) begin
      mfail = 0;
      mvalid = 1;
    end else begin
      if (mfail < MAXF) mfail++;
      mvalid = 0;
`ifdef AUTH_LOCKOUT_EN
      if (mfail == MAXF) mlock = 1;
`endif
    end
    prev = digest_valid;
    e.valid = mvalid;
    e.cnt = mfail;
    e.lock = mlock;
    sb_q.push_back(e);
    wr_ctrl(32'h1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      if (poke && n == 2) begin
        cs = 1; we = 1; wc = 0;
        address = 3'd3;
        write_data = 32'hdeadbeef;
      end else if (poke && n == 4) begin
        cs = 1; we = 1; wc = 1;
        write_data = 32'h3;
      end
      n++;
      tick();
      cs = 0; we = 0; wc = 0;
    end
    n_chk++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL %s busy_cycles got %0d want 8", tag, n);
    end
    n_chk++;
    if (digest_valid !== prev) begin
      n_fail++;
      $display("FAIL %s early_valid got %0b want %0b", tag,
               digest_valid, prev);
    end
    tick();
    got.valid = digest_valid;
    got.cnt = int'(fail_cnt);
    got.lock = locked;
    e = sb_q.pop_front();
    n_chk++;
    if (got.valid !== e.valid) begin
      n_fail++;
      $display("FAIL %s digest_valid got %0b want %0b", tag,
               got.valid, e.valid);
    end
    n_chk++;
    if (got.cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL %s fail_cnt got %0d want %0d", tag, got.cnt, e.cnt);
    end
    n_chk++;
    if (got.lock !== e.lock) begin
      n_fail++;
      $display("FAIL %s locked got %0b want %0b", tag, got.lock, e.lock);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    repeat (3) tick();
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick();
    tick();
    n_chk++;
    if ({digest_valid, busy, locked, fail_cnt} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset outputs got %b want 0000000",
               {digest_valid, busy, locked, fail_cnt});
    end
    reset_n = 1;
    repeat (3) tick();
    model_reset();
    n_chk++;
    if ({digest_valid, busy, locked, fail_cnt} !== 7'b0) begin
      n_fail++;
      $display("FAIL post_reset outputs got %b want 0000000",
               {digest_valid, busy, locked, fail_cnt});
    end
  endtask

  task automatic test_match();
    load_ref();
    do_compare("match", 0);
  endtask

  task automatic test_mismatch_fix();
    wr_word(5, 32'h0, 1);
    n_chk++;
    if (digest_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL word_wr_clears_valid got %0b want 0", digest_valid);
    end
    do_compare("bad_word5", 0);
    wr_word(5, refw[5], 1);
    do_compare("fixed_word5", 0);
  endtask

`ifdef AUTH_LOCKOUT_EN
  task automatic test_lockout();
    wr_word(2, 32'h12345678, 1);
    for (int k = 0; k < 3; k++) do_compare("lock_bad", 0);
    load_ref();
    mvalid = 0;
    wr_ctrl(32'h1);
    repeat (3) tick();
    n_chk++;
    if ({busy, digest_valid, locked} !== 3'b001) begin
      n_fail++;
      $display("FAIL locked_ignore got %b want 001",
               {busy, digest_valid, locked});
    end
    pulse_reset();
    n_chk++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_release got %0b want 0", locked);
    end
    load_ref();
    do_compare("after_unlock", 0);
  endtask
`else
  task automatic test_saturate();
    wr_word(2, 32'h12345678, 1);
    for (int k = 0; k < 5; k++) do_compare("sat_bad", 0);
    wr_word(2, refw[2], 1);
    do_compare("sat_recover", 0);
  endtask
`endif

  task automatic test_clear();
    wr_ctrl(32'h3);
    for (int i = 0; i < 8; i++) mcand[i] = '0;
    mvalid = 0;
    n_chk++;
    if ({digest_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_start got %b want 00", {digest_valid, busy});
    end
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_no_cmp busy got %0b want 0", busy);
    end
    do_compare("zeroed_cand", 0);
  endtask

  task automatic test_busy_writes();
    load_ref();
    do_compare("busy_poke", 1);
    do_compare("busy_recheck", 0);
  endtask

  task automatic test_back_to_back();
    do_compare("b2b_a", 0);
    do_compare("b2b_b", 0);
  endtask

  task automatic test_reset_mid();
    wr_ctrl(32'h1);
    repeat (3) tick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy got %0b want 1", busy);
    end
    #2;
    reset_n = 0;
    #1;
    n_chk++;
    if ({digest_valid, busy, locked, fail_cnt} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_reset outputs got %b want 0000000",
               {digest_valid, busy, locked, fail_cnt});
    end
    tick();
    reset_n = 1;
    repeat (3) tick();
    model_reset();
    n_chk++;
    if ({busy, fail_cnt} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_release got %b want 00000", {busy, fail_cnt});
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) refw[i] = REFD[i*32 +: 32];
    model_reset();
    test_reset();
    test_match();
    test_mismatch_fix();
`ifdef AUTH_LOCKOUT_EN
    test_lockout();
`else
    test_saturate();
`endif
    test_clear();
    test_busy_writes();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
